ide_target: RTL and testbench

IDE_TARGET -- requirements
Module: ide_target

---
 rtl/ide_target.sv | 202 ++++++++++++++++++++
 tb/tb_ide_target.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ide_target.sv
// IDE/ATA PIO target: host task-file registers, strobe-edge decoding and a
// sector-level handshake to a buffered storage backend.
module ide_target (
  input  logic        clk,
  input  logic        reset_n,
  inout  wire  [15:0] ide_data_bus,
  input  logic        ide_dior,
  input  logic        ide_diow,
  input  logic [1:0]  ide_cs,
  input  logic [2:0]  ide_da,
  output logic        ide_intrq,
  output logic        cmd_start,
  output logic [7:0]  cmd_code,
  output logic [27:0] cmd_lba,
  input  logic        sec_ready,
  input  logic        sec_err,
  input  logic [15:0] buf_rdata,
  output logic        buf_rd,
  output logic        buf_wr,
  output logic [15:0] buf_wdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DRQ_RD, DRQ_WR} state_t;

  state_t      state, state_next;
  logic        dior_q, diow_q;
  logic        srst, nien, intrq, err_bit, rd_cmd;
  logic [7:0]  error_reg, count, wcnt;
  logic [27:0] lba;
  logic [3:0]  dev_hi;
  logic [7:0]  status;
  logic [15:0] rd_data;

  logic rd_done, wr_done, tf_sel, ctl_sel;
  logic data_rd, data_wr, sec_end;
  logic cmd_wr, cmd_rd_ok, cmd_wr_ok, cmd_bad;
  logic tf_wr, ctl_wr, stat_rd;
  logic busy_err, busy_rdy, int_set, int_clr;

  // A strobe completes on its rising edge; cs/da/data are still held then.
  assign rd_done   = ide_dior & ~dior_q;
  assign wr_done   = ide_diow & ~diow_q;
  assign tf_sel    = (ide_cs == 2'b10);
  assign ctl_sel   = (ide_cs == 2'b01) && (ide_da == 3'd6);
  assign data_rd   = rd_done & tf_sel & (ide_da == 3'd0) & (state == DRQ_RD);
  assign data_wr   = wr_done & tf_sel & (ide_da == 3'd0) & (state == DRQ_WR);
  assign sec_end   = (data_rd | data_wr) & (wcnt == 8'hFF);
  assign cmd_wr    = wr_done & tf_sel & (ide_da == 3'd7) & (state == IDLE);
  assign cmd_rd_ok = cmd_wr & ((ide_data_bus[7:0] == 8'h20) | (ide_data_bus[7:0] == 8'hEC));
  assign cmd_wr_ok = cmd_wr & (ide_data_bus[7:0] == 8'h30);
  assign cmd_bad   = cmd_wr & ~cmd_rd_ok & ~cmd_wr_ok;
  assign tf_wr     = wr_done & tf_sel & (state == IDLE);
  assign ctl_wr    = wr_done & ctl_sel;
  assign stat_rd   = rd_done & tf_sel & (ide_da == 3'd7);
  assign busy_err  = (state == BUSY) & sec_err;
  assign busy_rdy  = (state == BUSY) & sec_ready & ~sec_err;
  assign int_set   = cmd_bad | busy_err | (busy_rdy & (rd_cmd | (count == 8'd0)));
  assign int_clr   = stat_rd | cmd_wr;

  assign status    = {(state == BUSY), (state != BUSY), 2'b00,
                      (state == DRQ_RD) || (state == DRQ_WR), 2'b00, err_bit};
  assign ide_intrq = intrq & ~nien;
  assign cmd_lba   = lba;

  always_comb begin
    rd_data = '0;
    if (tf_sel) begin
      unique case (ide_da)
        3'd0: rd_data = (state == DRQ_RD) ? buf_rdata : '0;
        3'd1: rd_data = {8'h00, error_reg};
        3'd2: rd_data = {8'h00, count};
        3'd3: rd_data = {8'h00, lba[7:0]};
        3'd4: rd_data = {8'h00, lba[15:8]};
        3'd5: rd_data = {8'h00, lba[23:16]};
        3'd6: rd_data = {8'h00, dev_hi, lba[27:24]};
        3'd7: rd_data = {8'h00, status};
        default: rd_data = '0;
      endcase
    end else if (ctl_sel) begin
      rd_data = {8'h00, status};
    end
  end

  assign ide_data_bus = (reset_n && !ide_dior && (ide_cs != 2'b11)) ? rd_data : 'z;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (cmd_rd_ok)      state_next = BUSY;
        else if (cmd_wr_ok) state_next = DRQ_WR;
      end
      BUSY: begin
        if (sec_err)        state_next = IDLE;
        else if (sec_ready) state_next = rd_cmd ? DRQ_RD :
                                         ((count == 8'd0) ? IDLE : DRQ_WR);
      end
      DRQ_RD: if (sec_end) state_next = (count == 8'd1) ? IDLE : BUSY;
      DRQ_WR: if (sec_end) state_next = BUSY;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dior_q <= 1'b1;
      diow_q <= 1'b1;
    end else begin
      dior_q <= ide_dior;
      diow_q <= ide_diow;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  state <= IDLE;
    else if (srst) state <= IDLE;
    else           state <= state_next;
  end

  // Features has no effect on the supported commands, so it is not stored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      srst      <= 1'b0;
      nien      <= 1'b0;
      intrq     <= 1'b0;
      err_bit   <= 1'b0;
      rd_cmd    <= 1'b1;
      error_reg <= '0;
      count     <= 8'd1;
      wcnt      <= '0;
      lba       <= '0;
      dev_hi    <= '0;
      cmd_start <= 1'b0;
      cmd_code  <= '0;
      buf_rd    <= 1'b0;
      buf_wr    <= 1'b0;
      buf_wdata <= '0;
    end else begin
      if (srst) begin
        nien      <= 1'b0;
        intrq     <= 1'b0;
        err_bit   <= 1'b0;
        rd_cmd    <= 1'b1;
        error_reg <= '0;
        count     <= 8'd1;
        wcnt      <= '0;
        lba       <= '0;
        dev_hi    <= '0;
        cmd_start <= 1'b0;
        buf_rd    <= 1'b0;
        buf_wr    <= 1'b0;
      end else begin
        cmd_start <= cmd_rd_ok | cmd_wr_ok;
        buf_rd    <= data_rd;
        buf_wr    <= data_wr;
        if (data_wr) buf_wdata <= ide_data_bus;

        if (cmd_rd_ok || cmd_wr_ok) begin
          err_bit  <= 1'b0;
          cmd_code <= ide_data_bus[7:0];
          rd_cmd   <= ~cmd_wr_ok;
          wcnt     <= '0;
          if (ide_data_bus[7:0] == 8'hEC) count <= 8'd1;
        end
        if (cmd_bad || busy_err) begin
          err_bit   <= 1'b1;
          error_reg <= 8'h04;
        end

        if (tf_wr) begin
          unique case (ide_da)
            3'd2: count       <= ide_data_bus[7:0];
            3'd3: lba[7:0]    <= ide_data_bus[7:0];
            3'd4: lba[15:8]   <= ide_data_bus[7:0];
            3'd5: lba[23:16]  <= ide_data_bus[7:0];
            3'd6: begin
              dev_hi      <= ide_data_bus[7:4];
              lba[27:24]  <= ide_data_bus[3:0];
            end
            default: ;
          endcase
        end

        if (data_rd || data_wr) wcnt <= wcnt + 8'd1;
        if (sec_end) begin
          lba   <= lba + 28'd1;
          count <= count - 8'd1;
        end

        if (int_set)      intrq <= 1'b1;
        else if (int_clr) intrq <= 1'b0;
      end

      // Device control stays writable during soft reset so the host can release it.
      if (ctl_wr) begin
        srst <= ide_data_bus[2];
        nien <= ide_data_bus[1];
      end
    end
  end

endmodule

// File: tb/tb_ide_target.sv
// Scoreboard bench for ide_target: stimulus tasks push expectations from a
// transaction-level model; a negedge monitor pops and compares DUT outputs.
module tb_ide_target;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        dior, diow;
  logic [1:0]  cs;
  logic [2:0]  da;
  logic        sec_ready, sec_err;
  logic [15:0] buf_rdata;
  logic        tb_drv;
  logic [15:0] tb_wdata;
  wire  [15:0] ide_data_bus;
  logic        ide_intrq, cmd_start, buf_rd, buf_wr;
  logic [7:0]  cmd_code;
  logic [27:0] cmd_lba;
  logic [15:0] buf_wdata;

  assign ide_data_bus = tb_drv ? tb_wdata : 16'hzzzz;

  ide_target dut (
    .clk(clk), .reset_n(reset_n), .ide_data_bus(ide_data_bus),
    .ide_dior(dior), .ide_diow(diow), .ide_cs(cs), .ide_da(da),
    .ide_intrq(ide_intrq), .cmd_start(cmd_start), .cmd_code(cmd_code),
    .cmd_lba(cmd_lba), .sec_ready(sec_ready), .sec_err(sec_err),
    .buf_rdata(buf_rdata), .buf_rd(buf_rd), .buf_wr(buf_wr), .buf_wdata(buf_wdata)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] rd_q[$];
  string       rd_tag_q[$];
  int          bufrd_q[$];
  logic [15:0] wr_q[$];
  logic [35:0] cmd_q[$];
  int          probe_kind_q[$];
  logic [15:0] probe_exp_q[$];
  logic        probe_req = 1'b0;
  logic        dior_prev = 1'b1;

  // Transaction-level model of the host-visible register state.
  logic [27:0] m_lba;
  logic [7:0]  m_cnt, m_error;
  logic [3:0]  m_dev_hi;
  logic        m_err, m_intr, m_nien, m_busy, m_drq, m_rd;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    check(name, {20'h0, act}, {20'h0, exp});
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && dior === 1'b0 && dior_prev === 1'b1 && cs !== 2'b11) begin
      if (rd_q.size() == 0) check("unexpected_read", 36'd1, 36'd0);
      else begin
        check16(rd_tag_q[0], ide_data_bus, rd_q[0]);
        void'(rd_q.pop_front());
        void'(rd_tag_q.pop_front());
      end
    end
    dior_prev <= dior;
    if (buf_rd === 1'b1) begin
      if (bufrd_q.size() == 0) check("unexpected_buf_rd", 36'd1, 36'd0);
      else void'(bufrd_q.pop_front());
    end
    if (buf_wr === 1'b1) begin
      if (wr_q.size() == 0) check("unexpected_buf_wr", 36'd1, 36'd0);
      else begin
        check16("buf_wdata", buf_wdata, wr_q[0]);
        void'(wr_q.pop_front());
      end
    end
    if (cmd_start === 1'b1) begin
      if (cmd_q.size() == 0) check("unexpected_cmd_start", 36'd1, 36'd0);
      else begin
        check("cmd_code_lba", {cmd_code, cmd_lba}, cmd_q[0]);
        void'(cmd_q.pop_front());
      end
    end
    if (probe_req) begin
      if (probe_kind_q.size() == 0) check("probe_queue", 36'd1, 36'd0);
      else begin
        case (probe_kind_q[0])
          0: check16("intrq", {15'h0, ide_intrq}, probe_exp_q[0]);
          1: check16("bus_released", {15'h0, (ide_data_bus === 16'hzzzz)}, probe_exp_q[0]);
          default: check16("pulse_outputs_idle", {13'h0, cmd_start, buf_rd, buf_wr}, probe_exp_q[0]);
        endcase
        void'(probe_kind_q.pop_front());
        void'(probe_exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] m_status();
    return {8'h00, m_busy, ~m_busy, 2'b00, m_drq, 2'b00, m_err};
  endfunction

  function automatic logic [15:0] exp_reg(input logic [1:0] c, input logic [2:0] a,
                                          input logic [15:0] w);
    if (c == 2'b10) begin
      case (a)
        3'd0: return (m_drq && m_rd) ? w : 16'h0000;
        3'd1: return {8'h00, m_error};
        3'd2: return {8'h00, m_cnt};
        3'd3: return {8'h00, m_lba[7:0]};
        3'd4: return {8'h00, m_lba[15:8]};
        3'd5: return {8'h00, m_lba[23:16]};
        3'd6: return {8'h00, m_dev_hi, m_lba[27:24]};
        default: return m_status();
      endcase
    end
    if (c == 2'b01 && a == 3'd6) return m_status();
    return 16'h0000;
  endfunction

  task automatic model_reset();
    m_lba = '0; m_cnt = 8'd1; m_error = '0; m_dev_hi = '0;
    m_err = 0; m_intr = 0; m_nien = 0; m_busy = 0; m_drq = 0; m_rd = 1;
  endtask

  task automatic probe(input int kind, input logic [15:0] exp);
    probe_kind_q.push_back(kind);
    probe_exp_q.push_back(exp);
    probe_req = 1'b1;
    @(negedge clk);
    #1 probe_req = 1'b0;
  endtask

  task automatic probe_intr();
    probe(0, {15'h0, m_intr & ~m_nien});
  endtask

  task automatic host_read(input logic [1:0] c, input logic [2:0] a);
    logic [15:0] w;
    @(posedge clk); #1;
    w = 16'($urandom());
    buf_rdata = w;
    cs = c; da = a; dior = 1'b0;
    rd_q.push_back(exp_reg(c, a, w));
    rd_tag_q.push_back($sformatf("read_cs%0d_da%0d", c, a));
    if (c == 2'b10 && a == 3'd0 && m_drq && m_rd) bufrd_q.push_back(1);
    @(posedge clk); #1 dior = 1'b1;
    @(posedge clk); #1 cs = 2'b11;
    if (c == 2'b10 && a == 3'd7) m_intr = 0;
  endtask

  task automatic host_write(input logic [1:0] c, input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    cs = c; da = a; tb_wdata = d; tb_drv = 1'b1; diow = 1'b0;
    @(posedge clk); #1 diow = 1'b1;
    @(posedge clk); #1 tb_drv = 1'b0; cs = 2'b11;
  endtask

  task automatic set_tf(input logic [27:0] l, input logic [7:0] n);
    host_write(2'b10, 3'd1, 16'($urandom()));
    host_write(2'b10, 3'd2, {8'h00, n});
    host_write(2'b10, 3'd3, {8'h00, l[7:0]});
    host_write(2'b10, 3'd4, {8'h00, l[15:8]});
    host_write(2'b10, 3'd5, {8'h00, l[23:16]});
    host_write(2'b10, 3'd6, {8'h00, 4'hE, l[27:24]});
    m_lba = l; m_cnt = n; m_dev_hi = 4'hE;
  endtask

  task automatic issue_cmd(input logic [7:0] code);
    bit ok;
    ok = (code == 8'h20) || (code == 8'hEC) || (code == 8'h30);
    if (ok) cmd_q.push_back({code, m_lba});
    host_write(2'b10, 3'd7, {8'h00, code});
    m_intr = 0;
    if (ok) begin
      m_err = 0;
      if (code == 8'hEC) m_cnt = 8'd1;
      m_rd = (code != 8'h30);
      m_busy = m_rd;
      m_drq = !m_rd;
    end else begin
      m_err = 1; m_error = 8'h04; m_intr = 1;
    end
  endtask

  task automatic sec_pulse(input logic r, input logic e);
    @(posedge clk); #1 sec_ready = r; sec_err = e;
    @(posedge clk); #1 sec_ready = 1'b0; sec_err = 1'b0;
    if (m_busy) begin
      if (e) begin
        m_busy = 0; m_err = 1; m_error = 8'h04; m_intr = 1;
      end else if (r) begin
        m_busy = 0;
        if (m_rd) begin m_drq = 1; m_intr = 1; end
        else if (m_cnt == 8'd0) m_intr = 1;
        else m_drq = 1;
      end
    end
  endtask

  task automatic read_words(input int n);
    for (int i = 0; i < n; i++) host_read(2'b10, 3'd0);
  endtask

  task automatic end_rd_sector();
    m_lba = m_lba + 28'd1;
    m_cnt = m_cnt - 8'd1;
    m_drq = 0;
    m_busy = (m_cnt != 8'd0);
  endtask

  task automatic read_sector();
    read_words(256);
    end_rd_sector();
  endtask

  task automatic write_sector(input bit incrementing);
    logic [15:0] d;
    for (int i = 0; i < 256; i++) begin
      d = incrementing ? 16'(i) : 16'($urandom());
      wr_q.push_back(d);
      host_write(2'b10, 3'd0, d);
    end
    m_lba = m_lba + 28'd1;
    m_cnt = m_cnt - 8'd1;
    m_drq = 0; m_busy = 1;
  endtask

  task automatic bad_code(output logic [7:0] code);
    do code = 8'($urandom()); while (code == 8'h20 || code == 8'h30 || code == 8'hEC);
  endtask

  initial begin
    logic [7:0] bc;
    reset_n = 1'b0; dior = 1'b1; diow = 1'b1; cs = 2'b11; da = '0;
    sec_ready = 1'b0; sec_err = 1'b0; buf_rdata = '0; tb_drv = 1'b0; tb_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    host_read(2'b10, 3'd7);
    host_read(2'b10, 3'd2);
    host_read(2'b01, 3'd6);
    host_read(2'b10, 3'd1);
    host_read(2'b10, 3'd3);
    host_read(2'b10, 3'd0);
    host_read(2'b01, 3'd0);
    probe_intr();
    probe(1, 16'd1);
    probe(2, 16'd0);

    // Two-sector read from 0x123, with an ignored task-file write mid-transfer
    set_tf(28'h0000123, 8'd2);
    issue_cmd(8'h20);
    host_read(2'b01, 3'd6);
    sec_pulse(1'b1, 1'b0);
    host_read(2'b01, 3'd6);
    probe_intr();
    read_words(10);
    host_write(2'b10, 3'd3, 16'h0055);
    read_words(246);
    end_rd_sector();
    host_read(2'b01, 3'd6);
    sec_pulse(1'b1, 1'b0);
    read_sector();
    host_read(2'b10, 3'd3);
    host_read(2'b10, 3'd4);
    host_read(2'b10, 3'd5);
    host_read(2'b10, 3'd2);
    host_read(2'b01, 3'd6);
    probe_intr();

    // Single-sector write of incrementing words
    set_tf(28'($urandom()), 8'd1);
    issue_cmd(8'h30);
    host_read(2'b01, 3'd6);
    write_sector(1'b1);
    host_read(2'b01, 3'd6);
    sec_pulse(1'b1, 1'b0);
    host_read(2'b01, 3'd6);
    probe_intr();
    host_read(2'b10, 3'd3);

    // Two-sector write of random words
    set_tf(28'($urandom()), 8'd2);
    issue_cmd(8'h30);
    write_sector(1'b0);
    sec_pulse(1'b1, 1'b0);
    host_read(2'b01, 3'd6);
    write_sector(1'b0);
    sec_pulse(1'b1, 1'b0);
    host_read(2'b10, 3'd7);
    probe_intr();

    // Unsupported commands
    for (int k = 0; k < 3; k++) begin
      bad_code(bc);
      issue_cmd(bc);
      host_read(2'b01, 3'd6);
      host_read(2'b10, 3'd1);
      probe_intr();
      host_read(2'b10, 3'd7);
      probe_intr();
    end

    // Interrupt masking via nIEN
    host_write(2'b01, 3'd6, 16'h0002);
    m_nien = 1;
    bad_code(bc);
    issue_cmd(bc);
    probe_intr();
    host_write(2'b01, 3'd6, 16'h0000);
    m_nien = 0;
    probe_intr();
    host_read(2'b10, 3'd7);

    // Identify forces count to 1 and clears ERR
    set_tf(28'($urandom()), 8'd5);
    issue_cmd(8'hEC);
    host_read(2'b01, 3'd6);
    host_read(2'b10, 3'd2);
    sec_pulse(1'b1, 1'b0);
    read_sector();
    host_read(2'b01, 3'd6);

    // LBA wraps at 28 bits
    set_tf(28'hFFFFFFF, 8'd1);
    issue_cmd(8'h20);
    sec_pulse(1'b1, 1'b0);
    read_sector();
    host_read(2'b10, 3'd3);
    host_read(2'b10, 3'd4);
    host_read(2'b10, 3'd5);
    host_read(2'b10, 3'd6);
    host_read(2'b01, 3'd6);

    // Count 0 means 256; backend error beats ready; error ignored when idle
    set_tf(28'($urandom()), 8'd0);
    issue_cmd(8'h20);
    sec_pulse(1'b1, 1'b0);
    read_sector();
    host_read(2'b01, 3'd6);
    host_read(2'b10, 3'd2);
    host_read(2'b10, 3'd3);
    sec_pulse(1'b1, 1'b1);
    host_read(2'b01, 3'd6);
    host_read(2'b10, 3'd1);
    probe_intr();
    sec_pulse(1'b0, 1'b1);
    host_read(2'b01, 3'd6);
    host_read(2'b10, 3'd7);
    probe_intr();

    // Soft reset at word 100 of a read
    set_tf(28'($urandom()), 8'd2);
    issue_cmd(8'h20);
    sec_pulse(1'b1, 1'b0);
    read_words(100);
    host_write(2'b01, 3'd6, 16'h0004);
    model_reset();
    host_read(2'b01, 3'd6);
    read_words(3);
    host_write(2'b01, 3'd6, 16'h0000);
    host_read(2'b10, 3'd7);
    host_read(2'b10, 3'd2);
    probe_intr();
    probe(2, 16'd0);

    // Hard reset mid-transfer takes effect without a clock edge
    set_tf(28'($urandom()), 8'd1);
    issue_cmd(8'h20);
    sec_pulse(1'b1, 1'b0);
    read_words(20);
    probe_intr();
    @(posedge clk); #2;
    reset_n = 1'b0;
    cs = 2'b10; da = 3'd0; dior = 1'b0;
    model_reset();
    probe_intr();
    probe(1, 16'd1);
    probe(2, 16'd0);
    @(posedge clk); #1 dior = 1'b1; cs = 2'b11;
    @(posedge clk); #1 reset_n = 1'b1;
    host_read(2'b10, 3'd7);
    host_read(2'b10, 3'd2);
    host_read(2'b10, 3'd3);
    host_read(2'b10, 3'd6);
    host_read(2'b10, 3'd1);

    repeat (4) @(posedge clk);
    #1;
    check("rd_q_drained", 36'(rd_q.size()), 36'd0);
    check("buf_rd_q_drained", 36'(bufrd_q.size()), 36'd0);
    check("buf_wr_q_drained", 36'(wr_q.size()), 36'd0);
    check("cmd_q_drained", 36'(cmd_q.size()), 36'd0);
    check("probe_q_drained", 36'(probe_kind_q.size()), 36'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
